// File: rtl/tick_seq_pkg.sv
// Shared encodings for the tick sequencer: command opcodes, FSM states and
// the smallest divide value the sequencer will run with.
package tick_seq_pkg;

  typedef enum logic [1:0] {
    OP_NOP   = 2'b00,
    OP_RUN   = 2'b01,
    OP_BURST = 2'b10,
    OP_STEP  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_BURST = 2'b10
  } state_e;

  localparam int unsigned MIN_DIV = 2;

endpackage

// File: rtl/tick_divider.sv
// Free-running clock-enable divider: counts 0..div-1 while enabled and
// flags the cycle in which the count is about to wrap back to zero.
module tick_divider #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic [CNT_W-1:0] div,
  output logic             wrap
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] count_r;

  assign wrap = enable && (count_r == (div - ONE));

  // Count register; clear wins over enable so an abort always restarts at zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_r <= '0;
    end else if (clear) begin
      count_r <= '0;
    end else if (enable) begin
      if (wrap) begin
        count_r <= '0;
      end else begin
        count_r <= count_r + ONE;
      end
    end else begin
      count_r <= count_r;
    end
  end

endmodule

// File: rtl/tick_sequencer.sv
// Command-driven tick controller: RUN, BURST and STEP sequences of one-cycle
// tick enables plus a phase level that toggles on each tick.
module tick_sequencer
  import tick_seq_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int BURST_W     = 8,
  parameter int DEFAULT_DIV = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_we,
  input  logic [CNT_W-1:0]   cfg_div,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [BURST_W-1:0] cmd_count,
  input  logic               stop,
  output logic               tick,
  output logic               phase,
  output logic               busy,
  output logic               done,
  output logic [BURST_W-1:0] remaining
);

  state_e             state_r, state_s;
  logic [CNT_W-1:0]   div_r, div_s;
  logic [BURST_W-1:0] remaining_s;
  logic               tick_s, phase_s, done_s, clear_s, wrap_s, accept_s;

  function automatic logic [CNT_W-1:0] clamp_div(input logic [CNT_W-1:0] d);
    if (d < CNT_W'(MIN_DIV)) begin
      return CNT_W'(MIN_DIV);
    end else begin
      return d;
    end
  endfunction

  assign cmd_ready = (state_r == ST_IDLE) && !stop;
  assign accept_s  = cmd_valid && cmd_ready;

  tick_divider #(.CNT_W(CNT_W)) u_divider (
    .clk    (clk),
    .reset  (reset),
    .clear  (clear_s),
    .enable (state_r != ST_IDLE),
    .div    (div_r),
    .wrap   (wrap_s)
  );

  // Next-state and next-output decode; stop outranks any wrap on the same edge.
  always_comb begin
    state_s     = state_r;
    div_s       = div_r;
    remaining_s = remaining;
    tick_s      = 1'b0;
    phase_s     = phase;
    done_s      = 1'b0;
    clear_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        clear_s     = 1'b1;
        remaining_s = '0;
        if (cfg_we) begin
          div_s = clamp_div(cfg_div);
        end else begin
          div_s = div_r;
        end
        if (accept_s) begin
          case (op_e'(cmd_op))
            OP_RUN: state_s = ST_RUN;
            OP_BURST: begin
              state_s     = ST_BURST;
              remaining_s = cmd_count;
            end
            OP_STEP: begin
              state_s     = ST_BURST;
              remaining_s = BURST_W'(1);
            end
            default: state_s = ST_IDLE;
          endcase
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (stop) begin
          state_s = ST_IDLE;
          clear_s = 1'b1;
        end else if (wrap_s) begin
          tick_s  = 1'b1;
          phase_s = !phase;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_BURST: begin
        if (stop) begin
          state_s     = ST_IDLE;
          clear_s     = 1'b1;
          remaining_s = '0;
        end else if (remaining == '0) begin
          // zero-length burst finishes immediately without ticking
          state_s = ST_IDLE;
          clear_s = 1'b1;
          done_s  = 1'b1;
        end else if (wrap_s) begin
          tick_s      = 1'b1;
          phase_s     = !phase;
          remaining_s = remaining - BURST_W'(1);
          if (remaining == BURST_W'(1)) begin
            state_s = ST_IDLE;
            done_s  = 1'b1;
          end else begin
            state_s = ST_BURST;
          end
        end else begin
          state_s = ST_BURST;
        end
      end
      default: begin
        state_s     = ST_IDLE;
        clear_s     = 1'b1;
        remaining_s = '0;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= ST_IDLE;
      div_r     <= CNT_W'(DEFAULT_DIV);
      remaining <= '0;
      tick      <= 1'b0;
      phase     <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_r   <= state_s;
      div_r     <= div_s;
      remaining <= remaining_s;
      tick      <= tick_s;
      phase     <= phase_s;
      done      <= done_s;
      busy      <= (state_s != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_tick_sequencer.sv
// Scoreboard bench for tick_sequencer: directed commands push expected
// tick/done events; a negedge monitor pops and compares each event.
module tb_tick_sequencer;
  import tick_seq_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cfg_we = 1'b0;
  logic [15:0] cfg_div = 16'd0;
  logic        cmd_valid = 1'b0;
  logic [1:0]  cmd_op = 2'b00;
  logic [7:0]  cmd_count = 8'd0;
  logic        stop = 1'b0;
  logic        cmd_ready, tick, phase, busy, done;
  logic [7:0]  remaining;

  tick_sequencer #(.CNT_W(16), .BURST_W(8), .DEFAULT_DIV(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .cfg_we    (cfg_we),
    .cfg_div   (cfg_div),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_count (cmd_count),
    .stop      (stop),
    .tick      (tick),
    .phase     (phase),
    .busy      (busy),
    .done      (done),
    .remaining (remaining)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         cyc;
    logic       tick;
    logic       done;
    logic       phase;
    logic [7:0] rem;
  } exp_t;
  exp_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int c, input logic t, input logic d, input logic p, input logic [7:0] r);
    exp_t e;
    e.cyc = c; e.tick = t; e.done = d; e.phase = p; e.rem = r;
    sb.push_back(e);
  endtask

  task automatic wait_until(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  // Issue one command at a negedge; acc is the cycle number of the accepting edge.
  task automatic send(input logic [1:0] op, input logic [7:0] cnt, input logic we,
                      input logic [15:0] dv, output int acc);
    check("cmd_ready_before_send", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_op = op; cmd_count = cnt; cfg_we = we; cfg_div = dv;
    acc = cyc + 1;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_op = 2'b00; cmd_count = 8'd0; cfg_we = 1'b0; cfg_div = 16'd0;
  endtask

  // Monitor: every tick or done pulse must match the next scoreboard entry.
  always @(negedge clk) begin
    if (reset && (tick || done)) begin
      if (sb.size() == 0) begin
        check("unexpected_event", {30'd0, tick, done}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("event_cycle", 32'(cyc), 32'(e.cyc));
        check("event_tick", 32'(tick), 32'(e.tick));
        check("event_done", 32'(done), 32'(e.done));
        check("event_phase", 32'(phase), 32'(e.phase));
        check("event_remaining", 32'(remaining), 32'(e.rem));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached with %0d events pending", sb.size());
    $fatal(1, "watchdog");
  end

  initial begin
    int a;
    #1;
    check("reset_tick", 32'(tick), 32'd0);
    check("reset_phase", 32'(phase), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_remaining", 32'(remaining), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // RUN at default divide 16, then stop between ticks
    send(OP_RUN, 8'd0, 1'b0, 16'd0, a);
    check("run_busy", 32'(busy), 32'd1);
    check("run_cmd_ready", 32'(cmd_ready), 32'd0);
    push(a + 16, 1'b1, 1'b0, 1'b1, 8'd0);
    push(a + 32, 1'b1, 1'b0, 1'b0, 8'd0);
    push(a + 48, 1'b1, 1'b0, 1'b1, 8'd0);
    wait_until(a + 50);
    stop = 1'b1;
    @(negedge clk);
    check("run_stop_busy", 32'(busy), 32'd0);
    check("run_stop_phase", 32'(phase), 32'd1);
    stop = 1'b0;
    #1 check("run_stop_ready", 32'(cmd_ready), 32'd1);
    @(negedge clk);

    // cfg_div=5 together with BURST 3
    send(OP_BURST, 8'd3, 1'b1, 16'd5, a);
    check("burst_rem_initial", 32'(remaining), 32'd3);
    push(a + 5,  1'b1, 1'b0, 1'b0, 8'd2);
    push(a + 10, 1'b1, 1'b0, 1'b1, 8'd1);
    push(a + 15, 1'b1, 1'b1, 1'b0, 8'd0);
    wait_until(a + 15);
    check("burst_done_ready", 32'(cmd_ready), 32'd1);
    wait_until(a + 16);
    check("burst_after_busy", 32'(busy), 32'd0);

    // cfg_div=0 clamps to 2, then STEP (cmd_count ignored)
    cfg_we = 1'b1; cfg_div = 16'd0;
    @(negedge clk);
    cfg_we = 1'b0;
    send(OP_STEP, 8'd7, 1'b0, 16'd0, a);
    check("step_rem", 32'(remaining), 32'd1);
    push(a + 2, 1'b1, 1'b1, 1'b1, 8'd0);
    wait_until(a + 3);
    check("step_after_busy", 32'(busy), 32'd0);
    check("step_after_phase", 32'(phase), 32'd1);

    // RUN div 4, stop exactly on the wrap edge
    send(OP_RUN, 8'd0, 1'b1, 16'd4, a);
    push(a + 4, 1'b1, 1'b0, 1'b0, 8'd0);
    push(a + 8, 1'b1, 1'b0, 1'b1, 8'd0);
    wait_until(a + 11);
    stop = 1'b1;
    @(negedge clk);
    check("wrapstop_tick", 32'(tick), 32'd0);
    check("wrapstop_done", 32'(done), 32'd0);
    check("wrapstop_busy", 32'(busy), 32'd0);
    check("wrapstop_phase", 32'(phase), 32'd1);
    check("wrapstop_ready_blocked", 32'(cmd_ready), 32'd0);
    stop = 1'b0;
    #1 check("wrapstop_ready", 32'(cmd_ready), 32'd1);
    @(negedge clk);

    // BURST of zero ticks
    send(OP_BURST, 8'd0, 1'b0, 16'd0, a);
    check("burst0_busy", 32'(busy), 32'd1);
    push(a + 1, 1'b0, 1'b1, 1'b1, 8'd0);
    wait_until(a + 2);
    check("burst0_after_busy", 32'(busy), 32'd0);

    // RUN div 8; cfg_we of 3 during the run must be ignored
    send(OP_RUN, 8'd0, 1'b1, 16'd8, a);
    push(a + 8,  1'b1, 1'b0, 1'b0, 8'd0);
    push(a + 16, 1'b1, 1'b0, 1'b1, 8'd0);
    push(a + 24, 1'b1, 1'b0, 1'b0, 8'd0);
    wait_until(a + 2);
    cfg_we = 1'b1; cfg_div = 16'd3;
    @(negedge clk);
    cfg_we = 1'b0; cfg_div = 16'd0;
    wait_until(a + 26);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check("cfgrun_phase", 32'(phase), 32'd0);
    @(negedge clk);

    // Async reset during a burst with remaining=2
    send(OP_BURST, 8'd3, 1'b0, 16'd0, a);
    push(a + 8, 1'b1, 1'b0, 1'b1, 8'd2);
    wait_until(a + 8);
    #2 reset = 1'b0;
    #1;
    check("async_tick", 32'(tick), 32'd0);
    check("async_phase", 32'(phase), 32'd0);
    check("async_busy", 32'(busy), 32'd0);
    check("async_remaining", 32'(remaining), 32'd0);
    check("async_done", 32'(done), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    send(OP_BURST, 8'd1, 1'b0, 16'd0, a);
    push(a + 16, 1'b1, 1'b1, 1'b1, 8'd0);
    wait_until(a + 17);
    check("post_reset_busy", 32'(busy), 32'd0);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
